// File: rtl/calc_entry_seq.sv
// Operand-entry sequencer: ENTRY -> OP_SEL -> OP_LOCK -> SHOW, steering digit/operator/clear strobes.
// Optional macro CALC_SEQ_EDGE_DETECT_EN: derive events from rising edges of registered inputs.
module calc_entry_seq #(
    parameter int N_OPERANDS = 2,
    parameter int MAX_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          exe,
    input  logic                          button,
    input  logic                          clear,
    output logic                          load_stb,
    output logic [$clog2(N_OPERANDS)-1:0] operand_idx,
    output logic [3:0]                    digit_cnt,
    output logic                          digit_full,
    output logic                          op_stb,
    output logic                          clr_stb,
    output logic [1:0]                    phase
);

    localparam int IDX_W = $clog2(N_OPERANDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPERANDS - 1);
    localparam logic [3:0]       MAX_CNT  = 4'(MAX_DIGITS);

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OP_SEL  = 2'd1,
        OP_LOCK = 2'd2,
        SHOW    = 2'd3
    } phase_t;

    phase_t state;
    logic   ev_exe, ev_btn, ev_clr;

`ifdef CALC_SEQ_EDGE_DETECT_EN
    logic exe_q, button_q, clear_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q    <= 1'b0;
            button_q <= 1'b0;
            clear_q  <= 1'b0;
        end else begin
            exe_q    <= exe;
            button_q <= button;
            clear_q  <= clear;
        end
    end

    assign ev_exe = exe & ~exe_q;
    assign ev_btn = button & ~button_q;
    assign ev_clr = clear & ~clear_q;
`else
    assign ev_exe = exe;
    assign ev_btn = button;
    assign ev_clr = clear;
`endif

    // Widened copies so the legality check stays meaningful for every parameter choice.
    logic [31:0] idx_ext, cnt_ext;
    logic        state_ok;
    assign idx_ext  = 32'(operand_idx);
    assign cnt_ext  = 32'(digit_cnt);
    assign state_ok = (idx_ext < 32'(N_OPERANDS)) && (cnt_ext <= 32'(MAX_DIGITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ENTRY;
            operand_idx <= '0;
            digit_cnt   <= 4'd0;
            load_stb    <= 1'b0;
            op_stb      <= 1'b0;
            clr_stb     <= 1'b0;
        end else begin
            load_stb <= 1'b0;
            op_stb   <= 1'b0;
            clr_stb  <= 1'b0;
            if (ev_clr || !state_ok) begin
                state       <= ENTRY;
                operand_idx <= '0;
                digit_cnt   <= 4'd0;
                clr_stb     <= ev_clr;
            end else begin
                case (state)
                    ENTRY: begin
                        if (ev_exe) begin
                            if (operand_idx < LAST_IDX) begin
                                operand_idx <= operand_idx + 1'b1;
                                digit_cnt   <= 4'd0;
                            end else begin
                                state <= OP_SEL;
                            end
                        end else if (ev_btn && (digit_cnt < MAX_CNT)) begin
                            load_stb  <= 1'b1;
                            digit_cnt <= digit_cnt + 4'd1;
                        end
                    end
                    OP_SEL: begin
                        if (!ev_exe && ev_btn) begin
                            op_stb <= 1'b1;
                            state  <= OP_LOCK;
                        end
                    end
                    OP_LOCK: begin
                        if (ev_exe) begin
                            state <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (ev_exe) begin
                            clr_stb     <= 1'b1;
                            state       <= ENTRY;
                            operand_idx <= '0;
                            digit_cnt   <= 4'd0;
                        end
                    end
                    default: begin
                        state       <= ENTRY;
                        operand_idx <= '0;
                        digit_cnt   <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign phase      = state;
    assign digit_full = (state == ENTRY) && (digit_cnt == MAX_CNT);

endmodule

// File: tb/tb_calc_entry_seq.sv
// Bench for calc_entry_seq: two instances (N=2 and N=3, MAX=4) checked against a rule-level model,
// plus a directed vector table and hand-written reset / held-input sequences.
module tb_calc_entry_seq;

    localparam int MAXD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic exe = 1'b0, button = 1'b0, clear = 1'b0;

    logic       load2, op2, clr2, full2;
    logic [0:0] idx2;
    logic [3:0] cnt2;
    logic [1:0] ph2;
    logic       load3, op3, clr3, full3;
    logic [1:0] idx3;
    logic [3:0] cnt3;
    logic [1:0] ph3;

    always #5 clk = ~clk;

    calc_entry_seq #(.N_OPERANDS(2), .MAX_DIGITS(MAXD)) dut2 (
        .clk(clk), .rst_n(rst_n), .exe(exe), .button(button), .clear(clear),
        .load_stb(load2), .operand_idx(idx2), .digit_cnt(cnt2), .digit_full(full2),
        .op_stb(op2), .clr_stb(clr2), .phase(ph2)
    );

    calc_entry_seq #(.N_OPERANDS(3), .MAX_DIGITS(MAXD)) dut3 (
        .clk(clk), .rst_n(rst_n), .exe(exe), .button(button), .clear(clear),
        .load_stb(load3), .operand_idx(idx3), .digit_cnt(cnt3), .digit_full(full3),
        .op_stb(op3), .clr_stb(clr3), .phase(ph3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase as 0..3, index and count as plain integers.
    int m_ph[2], m_idx[2], m_cnt[2];
    bit m_load[2], m_op[2], m_clr[2];
    bit h_e[2], h_b[2], h_c[2];

    function automatic int n_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ph[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
            m_load[k] = 0; m_op[k] = 0; m_clr[k] = 0;
            h_e[k] = 0; h_b[k] = 0; h_c[k] = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit b, input bit c);
        bit ee, eb, ec;
        for (int k = 0; k < 2; k++) begin
`ifdef CALC_SEQ_EDGE_DETECT_EN
            ee = e & ~h_e[k]; eb = b & ~h_b[k]; ec = c & ~h_c[k];
`else
            ee = e; eb = b; ec = c;
`endif
            h_e[k] = e; h_b[k] = b; h_c[k] = c;
            m_load[k] = 0; m_op[k] = 0; m_clr[k] = 0;
            if (ec) begin
                m_clr[k] = 1; m_ph[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
            end else if (m_ph[k] == 0) begin
                if (ee) begin
                    if (m_idx[k] < n_of(k) - 1) begin
                        m_idx[k]++; m_cnt[k] = 0;
                    end else begin
                        m_ph[k] = 1;
                    end
                end else if (eb && m_cnt[k] < MAXD) begin
                    m_load[k] = 1; m_cnt[k]++;
                end
            end else if (m_ph[k] == 1) begin
                if (!ee && eb) begin
                    m_op[k] = 1; m_ph[k] = 2;
                end
            end else if (m_ph[k] == 2) begin
                if (ee) m_ph[k] = 3;
            end else begin
                if (ee) begin
                    m_clr[k] = 1; m_ph[k] = 0; m_idx[k] = 0; m_cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_model();
        check("n2.load_stb", 32'(load2), 32'(m_load[0]));
        check("n2.op_stb", 32'(op2), 32'(m_op[0]));
        check("n2.clr_stb", 32'(clr2), 32'(m_clr[0]));
        check("n2.phase", 32'(ph2), m_ph[0]);
        check("n2.operand_idx", 32'(idx2), m_idx[0]);
        check("n2.digit_cnt", 32'(cnt2), m_cnt[0]);
        check("n2.digit_full", 32'(full2), 32'(m_ph[0] == 0 && m_cnt[0] == MAXD));
        check("n3.load_stb", 32'(load3), 32'(m_load[1]));
        check("n3.op_stb", 32'(op3), 32'(m_op[1]));
        check("n3.clr_stb", 32'(clr3), 32'(m_clr[1]));
        check("n3.phase", 32'(ph3), m_ph[1]);
        check("n3.operand_idx", 32'(idx3), m_idx[1]);
        check("n3.digit_cnt", 32'(cnt3), m_cnt[1]);
        check("n3.digit_full", 32'(full3), 32'(m_ph[1] == 0 && m_cnt[1] == MAXD));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".n2.outs"}, {24'd0, load2, op2, clr2, full2, idx2, ph2}, 32'd0);
        check({tag, ".n2.cnt"}, 32'(cnt2), 32'd0);
        check({tag, ".n3.outs"}, {23'd0, load3, op3, clr3, full3, idx3, ph3}, 32'd0);
        check({tag, ".n3.cnt"}, 32'(cnt3), 32'd0);
    endtask

    // Called at a falling edge; drives inputs, lets one rising edge pass, compares just after it.
    task automatic step(input bit e, input bit b, input bit c);
        exe = e; button = b; clear = c;
        @(posedge clk);
        model_step(e, b, c);
        #1;
        compare_model();
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        exe = 0; button = 0; clear = 0;
        rst_n = 0;
        #1;
        check_zero(tag);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1;
    endtask

    typedef struct {
        bit e, b, c;
        bit load, op, clr;
        int ph, idx, cnt;
        bit full;
    } vec_t;

    vec_t tbl[23];
    int   held_loads;

    initial begin
        // Pulses are always separated by an idle cycle, so the table holds in both event modes.
        tbl[0]  = '{0,1,0, 1,0,0, 0,0,1,0};
        tbl[1]  = '{0,1,0, 1,0,0, 0,0,2,0};
        tbl[2]  = '{0,1,0, 1,0,0, 0,0,3,0};
        tbl[3]  = '{0,1,0, 1,0,0, 0,0,4,1};
        tbl[4]  = '{0,1,0, 0,0,0, 0,0,4,1};
        tbl[5]  = '{1,1,0, 0,0,0, 0,1,0,0};
        tbl[6]  = '{0,1,0, 1,0,0, 0,1,1,0};
        tbl[7]  = '{1,0,0, 0,0,0, 0,2,0,0};
        tbl[8]  = '{1,0,0, 0,0,0, 1,2,0,0};
        tbl[9]  = '{1,0,0, 0,0,0, 1,2,0,0};
        tbl[10] = '{0,1,0, 0,1,0, 2,2,0,0};
        tbl[11] = '{0,1,0, 0,0,0, 2,2,0,0};
        tbl[12] = '{1,0,1, 0,0,1, 0,0,0,0};
        tbl[13] = '{1,0,0, 0,0,0, 0,1,0,0};
        tbl[14] = '{1,0,0, 0,0,0, 0,2,0,0};
        tbl[15] = '{1,0,0, 0,0,0, 1,2,0,0};
        tbl[16] = '{0,1,0, 0,1,0, 2,2,0,0};
        tbl[17] = '{1,0,0, 0,0,0, 3,2,0,0};
        tbl[18] = '{0,1,0, 0,0,0, 3,2,0,0};
        tbl[19] = '{1,0,0, 0,0,1, 0,0,0,0};
        tbl[20] = '{0,1,0, 1,0,0, 0,0,1,0};
        tbl[21] = '{0,0,1, 0,0,1, 0,0,0,0};
        tbl[22] = '{0,1,1, 0,0,1, 0,0,0,0};

        model_reset();
        @(negedge clk);
        do_reset("reset0");

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].e, tbl[i].b, tbl[i].c);
            check($sformatf("vec%0d.load_stb", i), 32'(load3), 32'(tbl[i].load));
            check($sformatf("vec%0d.op_stb", i), 32'(op3), 32'(tbl[i].op));
            check($sformatf("vec%0d.clr_stb", i), 32'(clr3), 32'(tbl[i].clr));
            check($sformatf("vec%0d.phase", i), 32'(ph3), tbl[i].ph);
            check($sformatf("vec%0d.operand_idx", i), 32'(idx3), tbl[i].idx);
            check($sformatf("vec%0d.digit_cnt", i), 32'(cnt3), tbl[i].cnt);
            check($sformatf("vec%0d.digit_full", i), 32'(full3), 32'(tbl[i].full));
            step(0, 0, 0);
        end

        // Held button: one event in edge mode, capped by MAX_DIGITS in level mode.
        do_reset("reset1");
        held_loads = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0);
            if (load2) held_loads++;
        end
        step(0, 0, 0);
`ifdef CALC_SEQ_EDGE_DETECT_EN
        check("held_button.loads", held_loads, 1);
`else
        check("held_button.loads", held_loads, MAXD);
`endif

        // Asynchronous reset while a load strobe is high, then first event after release.
        do_reset("reset2");
        step(0, 1, 0);
        check("pre_rst.load_stb", 32'(load2), 32'd1);
        do_reset("mid_strobe_rst");
        step(0, 1, 0);
        check("post_rst.load_stb", 32'(load2), 32'd1);
        check("post_rst.digit_cnt", 32'(cnt2), 32'd1);
        check("post_rst.operand_idx", 32'(idx3), 32'd0);
        step(0, 0, 0);

        // Random traffic against the model, clear kept rare so long entry sequences occur.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
